// File: rtl/sdram_req_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter and its address generators.
package sdram_req_arb_pkg;

  localparam int unsigned DefAddrW = 24;
  localparam int unsigned DefLenW  = 10;

  // Bank bit sits at ADDR_W - BankBitOffset, i.e. the low bit of bank[1:0].
  localparam int unsigned BankBitOffset = 2;

  typedef enum logic [2:0] {
    A_IDLE,
    A_WR_REQ,
    A_WR_BUSY,
    A_RD_REQ,
    A_RD_BUSY
  } arb_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-direction frame-buffer address stepper: burst increment, region wrap,
// deferred reload on load rising edge and ping-pong bank bit.
module sdram_addr_gen
  import sdram_req_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned LEN_W     = DefLenW,
  parameter bit          PINGPONG  = 1'b1,
  parameter bit          BANK_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              idle_i,
  input  logic              done_i,
  input  logic              bank_wrap_i,
  input  logic [ADDR_W-1:0] min_addr_i,
  input  logic [ADDR_W-1:0] max_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              bank_o,
  output logic              wrap_o
);

  localparam int unsigned BankBit = ADDR_W - BankBitOffset;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bank_q, bank_d;
  logic              pend_q, pend_d;
  logic              wrap_q, wrap_d;
  logic              load_q;
  logic              load_rise;
  logic              hit_max;
  logic [ADDR_W:0]   sum;

  assign load_rise = load_i & ~load_q;
  assign sum       = {1'b0, addr_q} + (ADDR_W + 1)'(len_i);
  assign hit_max   = sum >= {1'b0, max_addr_i};

  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    pend_d = pend_q;
    wrap_d = 1'b0;
    if (done_i) begin
      // A reload requested during the burst replaces the increment and keeps the bank.
      if (pend_q || load_rise) begin
        addr_d = min_addr_i;
        pend_d = 1'b0;
      end else if (hit_max) begin
        addr_d = min_addr_i;
        wrap_d = 1'b1;
        if (PINGPONG) begin
          bank_d = bank_wrap_i;
        end
      end else begin
        addr_d = sum[ADDR_W-1:0];
      end
    end else if (load_rise) begin
      if (idle_i) begin
        addr_d = min_addr_i;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      bank_q <= BANK_INIT;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
      load_q <= load_i;
    end
  end

  always_comb begin
    addr_o = addr_q;
    if (PINGPONG) begin
      addr_o[BankBit] = bank_q;
    end
  end

  assign bank_o = bank_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/sdram_req_arb.sv
// Decides between camera writes and LCD reads from FIFO fill levels and raises
// the SDRAM controller request with burst length and start address.
module sdram_req_arb
  import sdram_req_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned LEN_W       = DefLenW,
  parameter int unsigned RFIFO_DEPTH = 1024,
  parameter bit          PINGPONG    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_init_done_i,
  input  logic [LEN_W-1:0]  wfifo_used_i,
  input  logic [LEN_W-1:0]  rfifo_used_i,
  input  logic              rd_valid_i,
  input  logic              wr_load_i,
  input  logic              rd_load_i,
  input  logic [ADDR_W-1:0] wr_min_addr_i,
  input  logic [ADDR_W-1:0] wr_max_addr_i,
  input  logic [ADDR_W-1:0] rd_min_addr_i,
  input  logic [ADDR_W-1:0] rd_max_addr_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  input  logic              sdram_wr_ack_i,
  input  logic              sdram_rd_ack_i,
  output logic              sdram_wr_req_o,
  output logic              sdram_rd_req_o,
  output logic [LEN_W-1:0]  sdram_wr_burst_o,
  output logic [LEN_W-1:0]  sdram_rd_burst_o,
  output logic [ADDR_W-1:0] sdram_wr_addr_o,
  output logic [ADDR_W-1:0] sdram_rd_addr_o,
  output logic              wr_frame_done_o
);

  localparam logic [LEN_W:0] RdRoomMax = (LEN_W + 1)'(RFIFO_DEPTH - 1);

  arb_state_e state_q;
  logic       wr_req_q, rd_req_q;
  logic       wr_ack_q, rd_ack_q;
  logic       wr_done, rd_done;
  logic       rd_starve, wr_ready, rd_room;
  logic       wr_bank;
  logic       rd_bank_unused;
  logic       rd_wrap_unused;

  assign rd_starve = rd_valid_i & (rfifo_used_i < rd_len_i);
  assign wr_ready  = wfifo_used_i >= wr_len_i;
  // Room check written as a sum so rd_len never underflows the subtraction.
  assign rd_room   = rd_valid_i & (({1'b0, rfifo_used_i} + {1'b0, rd_len_i}) <= RdRoomMax);

  assign wr_done = (state_q == A_WR_BUSY) & wr_ack_q & ~sdram_wr_ack_i;
  assign rd_done = (state_q == A_RD_BUSY) & rd_ack_q & ~sdram_rd_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= A_IDLE;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= sdram_wr_ack_i;
      rd_ack_q <= sdram_rd_ack_i;
      unique case (state_q)
        A_IDLE: begin
          if (sdram_init_done_i) begin
            if (rd_starve) begin
              state_q  <= A_RD_REQ;
              rd_req_q <= 1'b1;
            end else if (wr_ready) begin
              state_q  <= A_WR_REQ;
              wr_req_q <= 1'b1;
            end else if (rd_room) begin
              state_q  <= A_RD_REQ;
              rd_req_q <= 1'b1;
            end
          end
        end
        A_WR_REQ: begin
          if (sdram_wr_ack_i) begin
            state_q  <= A_WR_BUSY;
            wr_req_q <= 1'b0;
          end
        end
        A_WR_BUSY: begin
          if (wr_done) state_q <= A_IDLE;
        end
        A_RD_REQ: begin
          if (sdram_rd_ack_i) begin
            state_q  <= A_RD_BUSY;
            rd_req_q <= 1'b0;
          end
        end
        A_RD_BUSY: begin
          if (rd_done) state_q <= A_IDLE;
        end
        default: begin
          state_q  <= A_IDLE;
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
        end
      endcase
    end
  end

  sdram_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .PINGPONG (PINGPONG),
    .BANK_INIT(1'b0)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wr_load_i),
    .idle_i     (state_q == A_IDLE),
    .done_i     (wr_done),
    .bank_wrap_i(~wr_bank),
    .min_addr_i (wr_min_addr_i),
    .max_addr_i (wr_max_addr_i),
    .len_i      (wr_len_i),
    .addr_o     (sdram_wr_addr_o),
    .bank_o     (wr_bank),
    .wrap_o     (wr_frame_done_o)
  );

  // Read bank follows the opposite of the write bank so it never reads the frame being filled.
  sdram_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .PINGPONG (PINGPONG),
    .BANK_INIT(1'b1)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rd_load_i),
    .idle_i     (state_q == A_IDLE),
    .done_i     (rd_done),
    .bank_wrap_i(~wr_bank),
    .min_addr_i (rd_min_addr_i),
    .max_addr_i (rd_max_addr_i),
    .len_i      (rd_len_i),
    .addr_o     (sdram_rd_addr_o),
    .bank_o     (rd_bank_unused),
    .wrap_o     (rd_wrap_unused)
  );

  assign sdram_wr_req_o   = wr_req_q;
  assign sdram_rd_req_o   = rd_req_q;
  assign sdram_wr_burst_o = wr_len_i;
  assign sdram_rd_burst_o = rd_len_i;

endmodule

// File: doc/sdram_req_arb.md
Name: sdram_req_arb

Overview:
- Upstream feeder of the SDRAM state controller.
- Watches the write-FIFO fill level (camera side) and the read-FIFO fill level (LCD side), then raises the write or read request with burst length and start address.
- Steps the frame-buffer address per burst and wraps it, with optional ping-pong bank swapping between write and read frames.
- The controller's write/read acks close each transaction.

Parameters:
- ADDR_W, 24, SDRAM linear word address width {bank[1:0],row[12:0],col[8:0]}.
- LEN_W, 10, burst length width; legal lengths 1..512.
- RFIFO_DEPTH, 1024, read-FIFO depth in words.
- PINGPONG, 1, 1 = alternate bank bit ADDR_W-2 per frame; 0 = single buffer.

Ports:
- clk  in  1  system clock (same as SDRAM controller).
- rst  in  1  asynchronous active-high reset.
- sdram_init_done  in  1  controller initialisation complete.
- wfifo_used  in  LEN_W  words currently readable from write FIFO.
- rfifo_used  in  LEN_W  words currently stored in read FIFO.
- rd_valid  in  1  display read path enabled.
- wr_load  in  1  level, restart write frame (rising edge acts).
- rd_load  in  1  level, restart read frame (rising edge acts).
- wr_min_addr / wr_max_addr  in  ADDR_W  write region [min,max).
- rd_min_addr / rd_max_addr  in  ADDR_W  read region [min,max).
- wr_len / rd_len  in  LEN_W  burst lengths.
- sdram_wr_ack  in  1  controller write ack, high while write data is taken.
- sdram_rd_ack  in  1  controller read ack, high while read data is delivered.
- sdram_wr_req  out  1  write request.
- sdram_rd_req  out  1  read request.
- sdram_wr_burst  out  LEN_W  write burst length.
- sdram_rd_burst  out  LEN_W  read burst length.
- sdram_wr_addr  out  ADDR_W  write start address.
- sdram_rd_addr  out  ADDR_W  read start address.
- wr_frame_done  out  1  one-cycle pulse on write-region wrap.

Behaviour:
- Reset (rst high, async): state=IDLE. All outputs 0 except: wr/rd addr = 0, wr/rd bank bits: write=0, read=1.
- sdram_wr_burst and sdram_rd_burst are combinational copies of wr_len and rd_len.
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY. No request is issued while sdram_init_done=0.
- IDLE, evaluated each cycle, in priority order:
  - (a) rd_valid & rfifo_used < rd_len → RD_REQ (display starving);
  - (b) wfifo_used >= wr_len → WR_REQ;
  - (c) rd_valid & rfifo_used <= RFIFO_DEPTH-1-rd_len → RD_REQ;
  - else stay.
- REQ states:
  - req output registered high from the cycle after the decision.
  - Held until the matching ack is sampled high, then → BUSY; req drops on that same edge.
- BUSY states: wait for the ack falling edge (ack was 1, now 0). On that edge:
  - address += len;
  - → IDLE.
  - Minimum idle gap is 1 cycle.
- Wrap rule (applied at burst completion): if addr+len >= max_addr → addr=min_addr; on the write side also pulse wr_frame_done.
- Ping-pong, PINGPONG=1:
  - on write wrap, write bank bit toggles;
  - on read wrap, read bank bit becomes ~write bank bit.
  - Read therefore never targets the frame being written.
  - Bank bit replaces address bit ADDR_W-2 on the output.
- Load pulses:
  - wr_load and rd_load are rising-edge detected with a 1-flop delay.
  - In IDLE the address is reset to min immediately.
  - In REQ/BUSY a pending flag is set and applied at completion instead of the increment; a reload does not toggle the bank.
- Arithmetic: addr+len is computed at ADDR_W+1 bits, with no overflow before compare.
- Ack unexpected (ack in IDLE or the wrong ack): ignored.
- Reset mid-operation: immediate return to IDLE, requests drop asynchronously.

Decomposition:
- Shared package/include:
  - FSM state encodings (A_IDLE..A_RD_BUSY);
  - ADDR_W/LEN_W defaults;
  - bank-bit position constant.
- One natural sub-module: sdram_addr_gen, instantiated twice (wr/rd). It contains the address register, the wrap compare, the load edge-detect/pending logic, and the bank bit.

Test Plan:
- Init hold: sdram_init_done=0, wfifo_used=600, wr_len=512 → no req. Raise init_done → sdram_wr_req=1 within 2 cycles, addr=0x000000.
- Write burst: ack high 512 cycles then low → req dropped the cycle after the first ack. Next sdram_wr_addr=0x000200, idle ≥1 cycle.
- Wrap/ping-pong: wr_min=0, wr_max=0x000400, wr_len=512. Two bursts → wr_frame_done pulse, addr=0, write bank bit=1. Next read wrap → read bank bit=0.
- Priority: rd_valid=1, rfifo_used=100, rd_len=256, wfifo_used=600 → RD_REQ issued first. With rfifo_used=800 → WR_REQ first.
- Load mid-burst: wr_load rises during WR_BUSY at addr 0x000200 → completion sets addr=wr_min (0x000000), not 0x000400, and the bank is unchanged.
- Async reset asserted in RD_REQ → sdram_rd_req=0 same cycle. After release, state=IDLE and all addresses are 0.
